// File: rtl/sram_1rw_256x32.sv
// ============================================================================
// Module  : sram_1rw_256x32
// Purpose : Single-port 256x32 SRAM, registered read port, gated output.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_1rw_256x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              CE,
  input  logic              reset,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] I,
  input  logic              WEB,
  input  logic              CSB,
  input  logic              OEB,
  output logic [DATA_W-1:0] O
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic              wr_en;
  logic              rd_en;

  assign wr_en = CSB &  WEB;
  assign rd_en = CSB & ~WEB;

  // Writes leave the read register untouched (no write-through).
  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      dout_d = mem_q[A];
    end
  end

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge CE or posedge reset) begin
    if (!reset && wr_en) begin
      mem_q[A] <= I;
    end
  end

  always_ff @(posedge CE or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign O = OEB ? dout_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_sram_1rw_256x32.sv
// ============================================================================
// Module  : tb_sram_1rw_256x32
// Purpose : Self-checking bench for sram_1rw_256x32 against an array model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_1rw_256x32;

  logic        CE = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  A = '0;
  logic [31:0] I = '0;
  logic        WEB = 1'b0;
  logic        CSB = 1'b1;
  logic        OEB = 1'b1;
  logic [31:0] O;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference: plain word array plus the value the last read returned.
  logic [31:0] ref_mem [256];
  logic [31:0] ref_out = '0;

  sram_1rw_256x32 #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) dut (
    .CE   (CE),
    .reset(reset),
    .A    (A),
    .I    (I),
    .WEB  (WEB),
    .CSB  (CSB),
    .OEB  (OEB),
    .O    (O)
  );

  always #5 CE = ~CE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_o();
    return OEB ? ref_out : 32'h0;
  endfunction

  // Drive one access, let one rising edge pass, update the model, check O.
  task automatic step(input string tag, input logic cs, input logic we,
                      input logic [7:0] addr, input logic [31:0] data);
    CSB = cs;
    WEB = we;
    A   = addr;
    I   = data;
    @(posedge CE);
    #1;
    if (!reset && cs) begin
      if (we) ref_mem[addr] = data;
      else    ref_out = ref_mem[addr];
    end
    chk(tag, O, exp_o());
    // Scramble inputs between edges; they must have no effect.
    A = 8'($urandom);
    I = $urandom;
  endtask

  task automatic assert_reset();
    reset   = 1'b1;
    ref_out = '0;
    #1;
  endtask

  logic [31:0] hold_val;

  initial begin
    // Reset with a read pending: O stays zero throughout.
    OEB = 1'b1;
    #1;
    chk("reset_async", O, 32'h0);
    for (int k = 0; k < 3; k++) step("reset_idle", 1'b1, 1'b0, 8'h00, 32'h0);
    reset = 1'b0;

    step("wr_00", 1'b1, 1'b1, 8'h00, 32'hDEADBEEF);
    step("wr_ff", 1'b1, 1'b1, 8'hFF, 32'h12345678);
    step("rd_00", 1'b1, 1'b0, 8'h00, 32'h0);
    chk("rd_00_const", O, 32'hDEADBEEF);
    step("rd_ff", 1'b1, 1'b0, 8'hFF, 32'h0);
    chk("rd_ff_const", O, 32'h12345678);

    // Writes must not disturb the read register.
    step("wr_10", 1'b1, 1'b1, 8'h10, 32'hA5A5A5A5);
    chk("wr_10_hold", O, 32'h12345678);
    step("wr_11", 1'b1, 1'b1, 8'h11, 32'h5A5A5A5A);
    chk("wr_11_hold", O, 32'h12345678);
    step("rd_10", 1'b1, 1'b0, 8'h10, 32'h0);
    chk("rd_10_const", O, 32'hA5A5A5A5);

    // Memory survives reset; writes during reset are ignored.
    step("wr_20", 1'b1, 1'b1, 8'h20, 32'hCAFEF00D);
    assert_reset();
    chk("rst_pulse_o", O, 32'h0);
    step("rst_wr_ign", 1'b1, 1'b1, 8'h20, 32'h11111111);
    reset = 1'b0;
    step("rd_20", 1'b1, 1'b0, 8'h20, 32'h0);
    chk("rd_20_const", O, 32'hCAFEF00D);

    // Chip select low holds; OEB gates combinationally.
    step("rd_11_csb0", 1'b0, 1'b0, 8'h11, 32'h0);
    chk("csb0_hold", O, 32'hCAFEF00D);
    OEB = 1'b0;
    step("rd_11_oeb0", 1'b1, 1'b0, 8'h11, 32'h0);
    chk("oeb0_zero", O, 32'h0);
    OEB = 1'b1;
    #1;
    chk("oeb1_comb", O, 32'h5A5A5A5A);

    // Reset landing on a pending read loses that read.
    CSB = 1'b1; WEB = 1'b0; A = 8'h00;
    assert_reset();
    chk("midread_rst", O, 32'h0);
    step("midread_edge", 1'b1, 1'b0, 8'h00, 32'h0);
    reset = 1'b0;
    step("after_rst_csb0", 1'b0, 1'b0, 8'h00, 32'h0);
    chk("midread_lost", O, 32'h0);

    // Fill every word, then stream it back one per cycle.
    for (int a = 0; a < 256; a++) step("fill", 1'b1, 1'b1, 8'(a), 32'(a) * 32'h01010101);
    for (int a = 0; a < 256; a++) begin
      step("readback", 1'b1, 1'b0, 8'(a), 32'h0);
      hold_val = 32'(a) * 32'h01010101;
      chk("readback_val", O, hold_val);
    end

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      OEB = ($urandom_range(0, 7) != 0);
      step("rand", ($urandom_range(0, 5) != 0), $urandom_range(0, 1) == 1,
           8'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
